// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display path: glyph table,
// segment bit positions and the per-digit slot payload.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned CNT_W      = 8;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Patterns are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef struct packed {
        logic [NIB_W-1:0] nibble;
        logic             dp;
        logic             err;
    } slot_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational segment-pattern to hex-nibble decoder; unknown patterns
// decode to zero with the error flag set.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [6:0]       patron_i,
    output logic [NIB_W-1:0] nibble_c_o,
    output logic             err_c_o
);

    always_comb begin
        nibble_c_o = '0;
        err_c_o    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (patron_i == GLYPH_TABLE[i]) begin
                nibble_c_o = NIB_W'(i);
                err_c_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lector_display.sv
// Multiplexed 7-segment bus reader: synchronizes the bus, waits for each
// digit slot to settle, decodes it and publishes complete 4-digit frames.
module lector_display
    import display_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W-1:0]            segmentos,
    input  logic [NUM_DIGITS-1:0]       sel_seg,
    output logic [NUM_DIGITS*NIB_W-1:0] digitos,
    output logic [NUM_DIGITS-1:0]       puntos,
    output logic [NUM_DIGITS-1:0]       error,
    output logic                        frame_valid
);

    localparam int unsigned BUS_W      = SEG_W + NUM_DIGITS;
    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_FIRE = CNT_W'(SETTLE_CYCLES - 1);

    logic [BUS_W-1:0]            sync1_q;
    logic [BUS_W-1:0]            bus_s_q;
    logic [BUS_W-1:0]            bus_prev_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    slot_t [NUM_DIGITS-1:0]      shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]       seen_q, seen_d;
    logic [NUM_DIGITS*NIB_W-1:0] digitos_q, digitos_d;
    logic [NUM_DIGITS-1:0]       puntos_q, puntos_d;
    logic [NUM_DIGITS-1:0]       error_q, error_d;
    logic                        frame_valid_q, frame_valid_d;

    logic [SEG_W-1:0]            seg_s;
    logic [NUM_DIGITS-1:0]       sel_s;
    logic [NIB_W-1:0]            dec_nibble_c;
    logic                        dec_err_c;
    logic                        changed_c;
    logic                        fire_c;
    logic                        valid_c;
    slot_t                       sample_c;

    assign {sel_s, seg_s} = bus_s_q;

    decodificador_7seg u_dec (
        .patron_i   (seg_s[SEG_G:SEG_A]),
        .nibble_c_o (dec_nibble_c),
        .err_c_o    (dec_err_c)
    );

    // Settle counter: restarts on any bus change, saturates so a long dwell fires once.
    always_comb begin
        changed_c = (bus_s_q != bus_prev_q);
        cnt_d     = cnt_q;
        if (changed_c) begin
            cnt_d = '0;
        end else if (cnt_q < SETTLE_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        fire_c  = (cnt_d == SETTLE_FIRE);
        valid_c = fire_c && is_onehot(sel_s);
    end

    always_comb begin
        sample_c.nibble = dec_nibble_c;
        sample_c.dp     = seg_s[SEG_DP];
        sample_c.err    = dec_err_c;
    end

    // Frame assembly; the completing sample is merged before the outputs load.
    always_comb begin
        shadow_d      = shadow_q;
        seen_d        = seen_q;
        digitos_d     = digitos_q;
        puntos_d      = puntos_q;
        error_d       = error_q;
        frame_valid_d = 1'b0;
        if (valid_c) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_s[i]) begin
                    shadow_d[i] = sample_c;
                end
            end
            seen_d = seen_q | sel_s;
            if (seen_d == '1) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digitos_d[i*NIB_W +: NIB_W] = shadow_d[i].nibble;
                    puntos_d[i]                 = shadow_d[i].dp;
                    error_d[i]                  = shadow_d[i].err;
                end
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            bus_s_q       <= '0;
            bus_prev_q    <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            seen_q        <= '0;
            digitos_q     <= '0;
            puntos_q      <= '0;
            error_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            sync1_q       <= {sel_seg, segmentos};
            bus_s_q       <= sync1_q;
            bus_prev_q    <= bus_s_q;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            seen_q        <= seen_d;
            digitos_q     <= digitos_d;
            puntos_q      <= puntos_d;
            error_q       <= error_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign digitos     = digitos_q;
    assign puntos      = puntos_q;
    assign error       = error_q;
    assign frame_valid = frame_valid_q;

endmodule
